// File: rtl/servo_pwm_gen_pkg.sv
// Shared types and 100 MHz default timing constants for the servo PWM generator.
package servo_pkg;

    localparam int POS_W = 8;
    localparam logic [POS_W-1:0] POS_RESET = 8'h80;

    localparam int FRAME_CYC_DEF = 2000000;
    localparam int MIN_CYC_DEF   = 100000;
    localparam int STEP_CYC_DEF  = 392;
    localparam int CNT_W_DEF     = 21;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } servo_state_t;

endpackage

// File: rtl/servo_pwm_gen_if.sv
// Position in / pulse out bundle between the position counter and one servo pin driver.
interface servo_pwm_gen_if;
    import servo_pkg::*;

    logic             en;
    logic [POS_W-1:0] pos;
    logic             pwm_out;
    logic             frame_start;
    logic [POS_W-1:0] pos_applied;

    modport master (
        output en,
        output pos,
        input  pwm_out,
        input  frame_start,
        input  pos_applied
    );

    modport slave (
        input  en,
        input  pos,
        output pwm_out,
        output frame_start,
        output pos_applied
    );

endinterface

// File: rtl/servo_pwm_gen_frame_timer.sv
// Frame counter for the servo PWM generator, flagging the last cycle of the
// frame and the last cycle of the pulse.
module servo_frame_timer #(
    parameter int FRAME_CYC = 2000000,
    parameter int CNT_W     = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_hiCyc,
    output logic             o_terminal,
    output logic             o_pulseEnd
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_terminal = (r_count == CNT_W'(FRAME_CYC - 1));
    assign o_pulseEnd = (r_count == (i_hiCyc - CNT_W'(1)));

endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: fixed frame period, pulse width linear in the
// position sampled at each frame boundary.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int FRAME_CYC = FRAME_CYC_DEF,
    parameter int MIN_CYC   = MIN_CYC_DEF,
    parameter int STEP_CYC  = STEP_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    servo_pwm_gen_if.slave   bus
);

    localparam logic [CNT_W-1:0] HI_RESET =
        CNT_W'(MIN_CYC) + CNT_W'(POS_RESET) * CNT_W'(STEP_CYC);

    servo_state_t     r_state;
    servo_state_t     w_nextState;
    logic             w_start;
    logic             w_clear;
    logic             w_enable;
    logic             w_terminal;
    logic             w_pulseEnd;
    logic [CNT_W-1:0] w_hiCycNext;
    logic [CNT_W-1:0] r_hiCyc;
    logic [POS_W-1:0] r_posApplied;
    logic             r_pwm;
    logic             r_frameStart;

    assign w_hiCycNext = CNT_W'(MIN_CYC) + CNT_W'(bus.pos) * CNT_W'(STEP_CYC);

    servo_frame_timer #(
        .FRAME_CYC (FRAME_CYC),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_enable   (w_enable),
        .i_hiCyc    (r_hiCyc),
        .o_terminal (w_terminal),
        .o_pulseEnd (w_pulseEnd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A frame ends only at terminal count, so en dropping never cuts a pulse short.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_clear     = 1'b0;
        w_enable    = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear = 1'b1;
                if (bus.en) begin
                    w_start     = 1'b1;
                    w_nextState = HIGH;
                end
            end
            HIGH: begin
                w_enable = 1'b1;
                if (w_pulseEnd) begin
                    w_nextState = LOW;
                end
            end
            LOW: begin
                w_enable = 1'b1;
                if (w_terminal) begin
                    w_clear = 1'b1;
                    if (bus.en) begin
                        w_start     = 1'b1;
                        w_nextState = HIGH;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm        <= 1'b0;
            r_frameStart <= 1'b0;
            r_posApplied <= POS_RESET;
            r_hiCyc      <= HI_RESET;
        end else begin
            r_pwm        <= (w_nextState == HIGH);
            r_frameStart <= w_start;
            if (w_start) begin
                r_posApplied <= bus.pos;
                r_hiCyc      <= w_hiCycNext;
            end
        end
    end

    assign bus.pwm_out     = r_pwm;
    assign bus.frame_start = r_frameStart;
    assign bus.pos_applied = r_posApplied;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: directed frame measurements plus
// randomized pos/en traffic compared every cycle against a frame-level model.
module tb_servo_pwm_gen;

    localparam int FRAME = 2000;
    localparam int MINC  = 100;
    localparam int STEP  = 4;
    localparam int CNTW  = 21;

    logic clk = 1'b0;
    logic rst_n;

    servo_pwm_gen_if tif();

    servo_pwm_gen #(
        .FRAME_CYC (FRAME),
        .MIN_CYC   (MINC),
        .STEP_CYC  (STEP),
        .CNT_W     (CNTW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    int cycleNo = 0;

    // Reference model: where we are inside the current frame and what it latched.
    bit         mActive;
    int         mT;
    int         mHi;
    logic [7:0] mPosApp;
    bit         mPwm;
    bit         mFs;
    logic       sRst;
    logic       sEn;
    logic [7:0] sPos;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cycleNo, actual, expected);
        end
    endtask

    initial begin
        mActive = 1'b0;
        mT      = 0;
        mHi     = 0;
        mPosApp = 8'h80;
        mPwm    = 1'b0;
        mFs     = 1'b0;
        forever begin
            @(posedge clk);
            sRst = rst_n;
            sEn  = tif.en;
            sPos = tif.pos;
            #1;
            cycleNo++;
            if (!sRst) begin
                mActive = 1'b0;
                mT      = 0;
                mPosApp = 8'h80;
                mFs     = 1'b0;
            end else begin
                mFs = 1'b0;
                if (!mActive) begin
                    mFs = sEn;
                end else if (mT == FRAME - 1) begin
                    if (sEn) mFs = 1'b1;
                    else     mActive = 1'b0;
                end else begin
                    mT++;
                end
                if (mFs) begin
                    mActive = 1'b1;
                    mT      = 0;
                    mHi     = MINC + int'(sPos) * STEP;
                    mPosApp = sPos;
                end
            end
            mPwm = mActive && (mT < mHi);
            checkOutput("cmp_pwm_out", int'(tif.pwm_out), int'(mPwm));
            checkOutput("cmp_frame_start", int'(tif.frame_start), int'(mFs));
            checkOutput("cmp_pos_applied", int'(tif.pos_applied), int'(mPosApp));
        end
    end

    task automatic applyStimulus(input logic newEn, input logic [7:0] newPos);
        tif.en  = newEn;
        tif.pos = newPos;
    endtask

    task automatic waitFrameStart(output int latency);
        latency = 0;
        for (int c = 1; c <= FRAME + 200; c++) begin
            @(negedge clk);
            if (tif.frame_start) begin
                latency = c;
                break;
            end
        end
    endtask

    // Called on the frame_start cycle; returns at the next frame_start (or bound).
    task automatic measureFrame(input int changeAt, input logic [7:0] newPos, input logic newEn,
                                output int hiCnt, output int period);
        hiCnt  = 0;
        period = 0;
        for (int c = 0; c < FRAME + 200; c++) begin
            if (c > 0 && tif.frame_start) begin
                period = c;
                break;
            end
            if (tif.pwm_out) hiCnt++;
            if (c == changeAt) applyStimulus(newEn, newPos);
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int hi;
        int per;

        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00);
        repeat (5) @(negedge clk);
        checkOutput("reset_pwm", int'(tif.pwm_out), 0);
        checkOutput("reset_pos_applied", int'(tif.pos_applied), 128);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("idle_pwm", int'(tif.pwm_out), 0);
        checkOutput("idle_frame_start", int'(tif.frame_start), 0);
        checkOutput("idle_pos_applied", int'(tif.pos_applied), 128);

        applyStimulus(1'b1, 8'd0);
        waitFrameStart(lat);
        checkOutput("start_latency", lat, 1);
        checkOutput("start_pwm", int'(tif.pwm_out), 1);
        checkOutput("start_pos_applied", int'(tif.pos_applied), 0);

        measureFrame(50, 8'd255, 1'b1, hi, per);
        checkOutput("hi_pos0", hi, 100);
        checkOutput("period_pos0", per, FRAME);
        checkOutput("pos_applied_255", int'(tif.pos_applied), 255);
        measureFrame(50, 8'd128, 1'b1, hi, per);
        checkOutput("hi_pos255", hi, 1120);
        checkOutput("period_pos255", per, FRAME);
        measureFrame(50, 8'd0, 1'b1, hi, per);
        checkOutput("hi_pos128", hi, 612);

        measureFrame(50, 8'd200, 1'b1, hi, per);
        checkOutput("hi_midchange", hi, 100);
        checkOutput("pos_applied_200", int'(tif.pos_applied), 200);
        measureFrame(30, 8'd0, 1'b1, hi, per);
        checkOutput("hi_pos200", hi, 900);
        checkOutput("period_pos200", per, FRAME);

        measureFrame(30, 8'd0, 1'b0, hi, per);
        checkOutput("hi_endrop", hi, 100);
        checkOutput("no_frame_after_endrop", per, 0);
        repeat (100) @(negedge clk);
        checkOutput("idle_after_endrop", int'(tif.pwm_out), 0);

        applyStimulus(1'b1, 8'd255);
        waitFrameStart(lat);
        checkOutput("restart_latency", lat, 1);
        repeat (500) @(negedge clk);
        checkOutput("pwm_before_reset", int'(tif.pwm_out), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pwm", int'(tif.pwm_out), 0);
        checkOutput("async_reset_pos_applied", int'(tif.pos_applied), 128);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        waitFrameStart(lat);
        checkOutput("post_reset_latency", lat, 1);
        for (int f = 0; f < 3; f++) begin
            measureFrame(-1, 8'd255, 1'b1, hi, per);
            checkOutput("b2b_hi", hi, 1120);
            checkOutput("b2b_period", per, FRAME);
        end

        for (int c = 0; c < 9000; c++) begin
            @(negedge clk);
            if ($urandom_range(299, 0) == 0) tif.pos = 8'($urandom_range(255, 0));
            if ($urandom_range(1499, 0) == 0) tif.en = ~tif.en;
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
Downstream stage of the 8-bit arm-joint position counter. Converts the 8-bit position `pos` into a standard hobby-servo PWM waveform with a fixed frame period and a pulse width linear in `pos`. The position is sampled once per frame into a shadow register, so a counter change mid-frame never produces a truncated or stretched pulse. One instance drives each joint servo pin.

Parameters:
FRAME_CYC, 2000000, frame period in clk cycles (20 ms at 100 MHz)
MIN_CYC, 100000, pulse width in cycles at pos = 0 (1 ms)
STEP_CYC, 392, added pulse cycles per position LSB (pos = 255 gives about 2 ms)
CNT_W, 21, frame counter width; must satisfy 2**CNT_W > FRAME_CYC
Legal configuration: MIN_CYC + 255*STEP_CYC < FRAME_CYC, and MIN_CYC >= 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  output enable; level-sensitive
pos  input  8  target position from the position counter, unsigned
pwm_out  output  1  servo control pulse, registered
frame_start  output  1  one-cycle pulse on the first cycle of every frame
pos_applied  output  8  position latched for the current frame

Behaviour:
- Reset (rst_n low, asynchronous):
  - pwm_out = 0, frame_start = 0, pos_applied = 8'h80 (mid-travel, matching the counter's power-up value).
  - Frame counter = 0; state = IDLE.
- States:
  - IDLE: pwm_out = 0, counter held at 0.
  - HIGH: pulse active.
  - LOW: remainder of the frame.
- IDLE -> HIGH:
  - On the first clk edge where en = 1.
  - On that edge: pos_applied <= pos, hi_cyc <= MIN_CYC + pos*STEP_CYC, counter <= 0, pwm_out <= 1, frame_start <= 1.
  - Latency from en rising to pwm_out rising is 1 clk.
- Frame timing:
  - Counter increments every clk while in HIGH or LOW.
  - pwm_out is high for exactly hi_cyc cycles, i.e. counter values 0 .. hi_cyc-1.
  - HIGH -> LOW on the edge where the counter reaches hi_cyc-1 (pwm_out <= 0).
  - The frame lasts exactly FRAME_CYC cycles.
- Frame boundary (LOW with counter = FRAME_CYC-1):
  - If en = 1: next frame starts immediately, with the same actions as IDLE -> HIGH. There is no gap between frames.
  - If en = 0: go to IDLE.
- en deasserted mid-frame: the current frame, including any pulse in progress, completes normally. No truncated pulse is ever emitted.
- pos changes mid-frame: ignored until the next frame boundary. pos_applied and hi_cyc are stable for the whole frame.
- frame_start is high only on the cycle pwm_out first goes high for a frame. It is 0 at all other times.
- Arithmetic:
  - pos*STEP_CYC is an unsigned constant multiply, zero-extended to CNT_W.
  - The sum must not overflow given the legal configuration.
  - hi_cyc is registered, not recomputed per cycle.
- Reset asserted mid-frame: pwm_out drops immediately (asynchronously). After release, the block waits in IDLE for en.

Decomposition:
- Shared package servo_pkg:
  - POS_W = 8, POS_RESET = 8'h80.
  - Default FRAME_CYC / MIN_CYC / STEP_CYC constants for 100 MHz.
  - State enum {IDLE, HIGH, LOW}.
- Sub-module servo_frame_timer:
  - Holds the CNT_W-bit frame counter with clear/enable inputs.
  - Outputs terminal-count flag (counter = FRAME_CYC-1) and a pulse-end compare against hi_cyc.
  - servo_pwm_gen keeps the FSM, shadow register and output flops.

Test Plan:
All tests use FRAME_CYC=2000, MIN_CYC=100, STEP_CYC=4.
1. Reset values: rst_n=0 then release, en=0 -> pwm_out=0, frame_start=0, pos_applied=0x80 and held indefinitely.
2. Endpoints and mid-range: en=1, pos=0 -> pwm high exactly 100 cycles per 2000-cycle frame. pos=255 -> 1120 high cycles. pos=128 -> 612 high cycles.
3. Mid-frame pos change: pos=0 at frame start, pos=200 at cycle 50 -> current pulse = 100 cycles, pos_applied stays 0. Next frame: pulse = 900 cycles, pos_applied=200.
4. Enable drop: en=1 for 1 frame + 30 cycles, then en=0 -> second pulse full 100 cycles, frame finishes at 2000 cycles, then IDLE with pwm=0 and no further frame_start.
5. Mid-pulse reset: pos=255, assert rst_n at cycle 500 of HIGH -> pwm_out=0 within the same cycle (async). After release with en=1, a full new frame starts 1 cycle later with frame_start=1.
6. Back-to-back frames: en held high for 3 frames -> frame_start pulses exactly 2000 cycles apart, no idle cycle between frames.
